// File: rtl/amax10_pio_pkg.sv
// Shared register map for the blinking Avalon-MM output PIO.
// Address decode constants and the STATUS bit layout used by the top and the bench.
package amax10_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/amax10_qsys_pio_blink_if.sv
// Avalon-MM slave bus bundle for the PIO: zero-latency reads, writes strobed by chipselect & ~write_n.
// No waitrequest; the slave always accepts in the same cycle.
interface amax10_qsys_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/amax10_pio_blink_timer.sv
// Free-running blink prescaler: phase flips every load_val+1 cycles; load restarts at phase 0.
// Single-cycle update, no backpressure.
module amax10_pio_blink_timer #(
  parameter int unsigned          PRESC_W          = 24,
  parameter logic [PRESC_W-1:0]   DEFAULT_PRESCALE = PRESC_W'(2499999)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  output logic               phase
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;

  // load_val doubles as the terminal-count reload value when no load is pending
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load) begin
      cnt_d   = load_val;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = load_val;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= DEFAULT_PRESCALE;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/amax10_qsys_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear and per-bit blink; writes visible right after the edge.
// Zero read latency, always ready (no waitrequest).
module amax10_qsys_pio_blink
  import amax10_pio_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH       = 8,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE      = '0,
  parameter int unsigned             PRESC_W          = 24,
  parameter logic [PRESC_W-1:0]      DEFAULT_PRESCALE = PRESC_W'(2499999)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  amax10_qsys_pio_blink_if.slave    bus,
  output logic [DATA_WIDTH-1:0]     out_port
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] blink_en_q, blink_en_d;
  logic [PRESC_W-1:0]    prescale_q, prescale_d;
  logic                  phase;
  logic                  wr_en;
  logic                  presc_load;
  logic [PRESC_W-1:0]    presc_val;
  logic [DATA_WIDTH-1:0] wdata_dw;
  logic                  wdata_unused;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata_dw     = bus.writedata[DATA_WIDTH-1:0];
  assign wdata_unused = ^bus.writedata;

  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    prescale_d = prescale_q;
    if (wr_en) begin
      unique case (bus.address)
        ADDR_DATA:     data_d     = wdata_dw;
        ADDR_BLINK_EN: blink_en_d = wdata_dw;
        ADDR_PRESCALE: prescale_d = bus.writedata[PRESC_W-1:0];
        ADDR_OUTSET:   data_d     = data_q | wdata_dw;
        ADDR_OUTCLEAR: data_d     = data_q & ~wdata_dw;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      prescale_q <= DEFAULT_PRESCALE;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      prescale_q <= prescale_d;
    end
  end

  // A PRESCALE write reloads the timer with the new value in the same edge
  assign presc_load = wr_en && (bus.address == ADDR_PRESCALE);
  assign presc_val  = presc_load ? bus.writedata[PRESC_W-1:0] : prescale_q;

  amax10_pio_blink_timer #(
    .PRESC_W          (PRESC_W),
    .DEFAULT_PRESCALE (DEFAULT_PRESCALE)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (presc_load),
    .load_val (presc_val),
    .phase    (phase)
  );

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:     bus.readdata = 32'(data_q);
      ADDR_BLINK_EN: bus.readdata = 32'(blink_en_q);
      ADDR_PRESCALE: bus.readdata = 32'(prescale_q);
      ADDR_STATUS:   bus.readdata[STATUS_PHASE_BIT] = phase;
      default:       ;
    endcase
  end

  assign out_port = data_q & ~(blink_en_q & {DATA_WIDTH{phase}});

endmodule

// File: tb/tb_amax10_qsys_pio_blink.sv
// Bench for the blinking PIO: constant vector table, hand-built blink/reset sequences,
// then random bus traffic against a time-based reference model.
module tb_amax10_qsys_pio_blink;
  import amax10_pio_pkg::*;

  localparam logic [7:0]  RV  = 8'hA5;
  localparam logic [23:0] DEF = 24'd7;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         n_total;
  int         n_pass;

  amax10_qsys_pio_blink_if bus();

  amax10_qsys_pio_blink #(
    .DATA_WIDTH       (8),
    .RESET_VALUE      (RV),
    .PRESC_W          (24),
    .DEFAULT_PRESCALE (DEF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase is derived from elapsed edges since the last timer load.
  logic [7:0]      m_data;
  logic [7:0]      m_ben;
  longint unsigned m_presc;
  longint unsigned m_edge;
  longint unsigned m_t0;

  function automatic logic m_phase();
    return 1'(((m_edge - m_t0) / (m_presc + 1)) % 2);
  endfunction

  function automatic logic [7:0] m_out();
    return m_data & ~(m_ben & {8{m_phase()}});
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      ADDR_DATA:     return {24'd0, m_data};
      ADDR_BLINK_EN: return {24'd0, m_ben};
      ADDR_PRESCALE: return 32'(m_presc);
      ADDR_STATUS:   return {31'd0, m_phase()};
      default:       return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    m_edge++;
    if (!reset_n) begin
      m_data  = RV;
      m_ben   = 8'h00;
      m_presc = longint'(DEF);
      m_t0    = m_edge;
    end else if (bus.chipselect && !bus.write_n) begin
      case (bus.address)
        ADDR_DATA:     m_data = bus.writedata[7:0];
        ADDR_BLINK_EN: m_ben  = bus.writedata[7:0];
        ADDR_PRESCALE: begin
          m_presc = longint'(bus.writedata[23:0]);
          m_t0    = m_edge;
        end
        ADDR_OUTSET:   m_data = m_data | bus.writedata[7:0];
        ADDR_OUTCLEAR: m_data = m_data & ~bus.writedata[7:0];
        default:       ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  typedef struct {
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_edge  = 0;
    m_t0    = 0;
    m_data  = 8'h00;
    m_ben   = 8'h00;
    m_presc = 0;
    vecs[0] = '{1'b1, ADDR_DATA,     32'hFFFF_FF3C, 8'h3C};
    vecs[1] = '{1'b0, ADDR_DATA,     32'h0000_0055, 8'h3C};
    vecs[2] = '{1'b1, ADDR_OUTSET,   32'h0000_0081, 8'hBD};
    vecs[3] = '{1'b1, ADDR_OUTCLEAR, 32'h0000_000C, 8'hB1};
    vecs[4] = '{1'b1, ADDR_STATUS,   32'hFFFF_FFFF, 8'hB1};
    vecs[5] = '{1'b1, 3'd6,          32'hFFFF_FFFF, 8'hB1};
    vecs[6] = '{1'b1, ADDR_BLINK_EN, 32'hFFFF_FF00, 8'hB1};

    reset_n        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    step();
    step();
    chk("reset_out", {24'd0, out_port}, 32'h0000_00A5);
    rd_chk("reset_rd_data", ADDR_DATA, 32'h0000_00A5);
    rd_chk("reset_rd_status", ADDR_STATUS, 32'd0);
    rd_chk("reset_rd_presc", ADDR_PRESCALE, 32'd7);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      bus.chipselect = vecs[i].cs;
      bus.write_n    = 1'b0;
      bus.address    = vecs[i].addr;
      bus.writedata  = vecs[i].wd;
      step();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      chk($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
      rd_chk($sformatf("vec%0d_rd_data", i), ADDR_DATA, {24'd0, vecs[i].exp_out});
    end
    rd_chk("rd_outset_zero", ADDR_OUTSET, 32'd0);
    rd_chk("rd_outclear_zero", ADDR_OUTCLEAR, 32'd0);
    rd_chk("rd_reserved_zero", 3'd7, 32'd0);

    // Blink: PRESCALE=3 loaded at k=0, DATA written at k=2
    wr(ADDR_PRESCALE, 32'd3);
    wr(ADDR_BLINK_EN, 32'h01);
    wr(ADDR_DATA, 32'h03);
    for (int k = 3; k <= 12; k++) begin
      step();
      chk($sformatf("blink_out_k%0d", k), {24'd0, out_port}, ((k / 4) % 2) ? 32'h02 : 32'h03);
      rd_chk($sformatf("blink_status_k%0d", k), ADDR_STATUS, 32'((k / 4) % 2));
    end

    // PRESCALE=0 toggles every cycle
    wr(ADDR_PRESCALE, 32'd0);
    rd_chk("p0_status_k0", ADDR_STATUS, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      rd_chk($sformatf("p0_status_k%0d", k), ADDR_STATUS, 32'(k % 2));
    end
    // now phase=0; one more edge makes phase=1, then reload with 5
    step();
    rd_chk("reload_pre_phase", ADDR_STATUS, 32'd1);
    wr(ADDR_PRESCALE, 32'd5);
    rd_chk("reload_phase0", ADDR_STATUS, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      rd_chk($sformatf("reload_status_k%0d", k), ADDR_STATUS, (k == 6) ? 32'd1 : 32'd0);
    end

    // Reset mid-blink
    wr(ADDR_BLINK_EN, 32'hFF);
    wr(ADDR_PRESCALE, 32'd0);
    step();
    rd_chk("mid_phase1", ADDR_STATUS, 32'd1);
    reset_n = 1'b0;
    #2;
    chk("rst_noedge_out", {24'd0, out_port}, 32'd0);
    rd_chk("rst_noedge_status", ADDR_STATUS, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_mid_out", {24'd0, out_port}, 32'h0000_00A5);
    rd_chk("rst_mid_ben", ADDR_BLINK_EN, 32'd0);
    rd_chk("rst_mid_status", ADDR_STATUS, 32'd0);
    for (int k = 1; k <= 7; k++) step();
    rd_chk("rst_cnt_k7", ADDR_STATUS, 32'd0);
    step();
    rd_chk("rst_cnt_k8", ADDR_STATUS, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] wd;
      logic [2:0]  ra;
      wd = $urandom();
      bus.address    = 3'($urandom_range(0, 7));
      if (bus.address == ADDR_PRESCALE) wd = {wd[31:24], 21'd0, wd[2:0]};
      bus.writedata  = wd;
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 2) == 0);
      reset_n        = ($urandom_range(0, 59) != 0);
      step();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      reset_n        = 1'b1;
      chk($sformatf("rand%0d_out", n), {24'd0, out_port}, {24'd0, m_out()});
      ra = 3'($urandom_range(0, 7));
      rd_chk($sformatf("rand%0d_rd%0d", n, ra), ra, m_rd(ra));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
